iterative_shifter: RTL
======================

Name: iterative_shifter

Overview:
- Multi-cycle, one-bit-per-cycle shift unit for the multicycle MIPS datapath. Serves as the area-lean sequential alternative to the single-cycle combinational shifter.
- The control FSM issues a start pulse with opcode, amount and operand, then waits for done before writing the result to the register file.
- Opcode encoding is the same as the datapath shifter, so the control unit drives either unit unchanged.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE or DONE.
- shift_ctrl  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved (see Optional Feature).
- shamt  in  SHAMT_W  shift amount, unsigned.
- shift_in  in  WIDTH  operand, treated as signed for SRA.
- busy  out  1  high while shifting (state SHIFT).
- done  out  1  one-cycle pulse when shift_out holds the final result.
- shift_out  out  WIDTH  result register.

Behaviour:
- Reset: one clock, asynchronous active-low reset.
  - reset_n low forces state IDLE, shift_out=0, count=0, op=00, busy=0, done=0 immediately, independent of clk.
  - Reset asserted mid-operation aborts the shift; no done is produced.
- States: IDLE, SHIFT, DONE.
- Accepting a request: start high on a rising edge while in IDLE or DONE, called edge T0, does all of the following:
  - shift_out<=shift_in, count<=shamt, op<=shift_ctrl.
  - Next state is DONE if shamt==0 or shift_ctrl==11 (feature off); otherwise SHIFT.
- SHIFT, each edge:
  - shift_out<=step(shift_out, op), count<=count-1.
  - If count==1, next state is DONE.
- One-bit step rules:
  - SLL fills the LSB with 0.
  - SRL fills the MSB with 0.
  - SRA replicates the old MSB.
- DONE: done=1 and busy=0 for exactly one cycle.
  - Next state is IDLE, unless start=1, which is accepted as a new request (back-to-back).
- Latency: done is asserted shamt+1 cycles after the start edge (shamt=0 gives 1; shamt=31 gives 32).
- start while in SHIFT is ignored and does not restart or queue.
- Inputs are captured at start; later changes to shift_in, shamt or shift_ctrl have no effect on an operation in flight.
- shift_out holds the last result in IDLE until the next accepted start.
- Boundaries:
  - Maximum shamt is 2^SHAMT_W-1; no wrap-around.
  - SRA of a negative operand by 31 gives 0xFFFFFFFF.
  - SLL by 31 keeps only bit 0.

Optional Feature:
- Macro: SHIFT_ROR_EN.
- Defined: shift_ctrl=11 is rotate right (ROR), iterated exactly like the shifts.
  - Each step moves bit 0 into the MSB.
  - Latency is shamt+1.
- Undefined: 11 is pass-through.
  - shift_out=shift_in, done after 1 cycle regardless of shamt.

Decomposition:
- Package shift_pkg:
  - opcode localparams SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR.
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE.
  - default WIDTH and SHAMT_W constants.
- Sub-module shift_step: purely combinational single-bit shift of WIDTH bits selected by op, including the ROR branch under the macro. The top holds the FSM, counter and result register.

Test Plan:
- Reset: assert reset_n=0 mid-SHIFT (SRL, shamt=20) → outputs are 0 immediately, state IDLE, no done pulse. After release, a new start completes normally.
- SLL, shift_in=0x00000001, shamt=4 → busy for 4 cycles; done in cycle 5 after start; shift_out=0x00000010.
- SRA, shift_in=0x80000000, shamt=31 → done at cycle 32; shift_out=0xFFFFFFFF. SRL with the same inputs → 0x00000001.
- shamt=0 (SLL, 0xDEADBEEF) → done 1 cycle after start, busy never high, shift_out=0xDEADBEEF.
- start re-pulsed during SHIFT (SRL, 0xF0000000, shamt=8) and again in the DONE cycle:
  - first result 0x00F00000, unaffected by the mid-shift pulse;
  - the DONE-cycle start is accepted back-to-back.
- shift_ctrl=11, shift_in=0x00000003, shamt=1:
  - with SHIFT_ROR_EN → 0x80000001 at cycle 2;
  - without it → 0x00000003 at cycle 1.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared opcodes, FSM state encoding and default sizes for the iterative shifter.
package shift_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    // Same encoding as the single-cycle datapath shifter
    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit shift selected by op; rotate-right branch exists only
// when SHIFT_ROR_EN is defined, otherwise opcode 11 passes data through.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_op)
            SHIFT_SLL: o_data = {i_data[WIDTH-2:0], 1'b0};
            SHIFT_SRL: o_data = {1'b0, i_data[WIDTH-1:1]};
            SHIFT_SRA: o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
`ifdef SHIFT_ROR_EN
            SHIFT_ROR: o_data = {i_data[0], i_data[WIDTH-1:1]};
`endif
            default:   o_data = i_data;
        endcase
    end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: one bit per clock, done pulses shamt+1 cycles after start.
// Optional rotate-right for opcode 11 is enabled by defining SHIFT_ROR_EN.
module iterative_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         shift_ctrl,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   shift_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   shift_out
);

`ifdef SHIFT_ROR_EN
    localparam bit ROR_EN = 1'b1;
`else
    localparam bit ROR_EN = 1'b0;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SHAMT_W-1:0] r_count;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_step;
    logic               w_accept;
    logic               w_quick;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // Zero-length shifts and pass-through complete straight from the load edge
    assign w_quick  = (shamt == '0) || (!ROR_EN && (shift_ctrl == SHIFT_ROR));

    shift_step #(.WIDTH(WIDTH)) u_step (
        .i_data (r_result),
        .i_op   (r_op),
        .o_data (w_step)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept)
                    w_state_nxt = w_quick ? ST_DONE : ST_SHIFT;
                else
                    w_state_nxt = ST_IDLE;
            end
            ST_SHIFT: begin
                if (r_count == SHAMT_W'(1))
                    w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_op     <= SHIFT_SLL;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_result <= shift_in;
                r_count  <= shamt;
                r_op     <= shift_ctrl;
            end else if (r_state == ST_SHIFT) begin
                r_result <= w_step;
                r_count  <= r_count - SHAMT_W'(1);
            end
        end
    end

    assign busy      = (r_state == ST_SHIFT);
    assign done      = (r_state == ST_DONE);
    assign shift_out = r_result;

endmodule
